// File: rtl/seg_pkg.sv
// Shared constants for the 9-segment scan driver:
// glyph table, segment bit positions and the all-off pattern.
package seg_pkg;

  localparam int SEG_A  = 8;
  localparam int SEG_B  = 7;
  localparam int SEG_C  = 6;
  localparam int SEG_D  = 5;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 3;
  localparam int SEG_G  = 2;
  localparam int SEG_DP = 1;

  localparam logic [8:0] SEG_OFF = 9'b0;

  // a..g, MSB = a
  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/seg9_hex_lut.sv
// Hex nibble to a..g glyph lookup with a forced-blank input.
// Purely combinational.
module seg9_hex_lut
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] glyph
);

  assign glyph = blank ? 7'b0 : GLYPH[nib];

endmodule

// File: rtl/seg_scan_display.sv
// Time-multiplexed hex display driver with shadow/display
// double buffering, leading-zero blanking and slot blank gap.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DIGITS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 4,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   in_value,
  input  logic [DIGITS-1:0]     in_dp,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  lz_blank,
  output logic [8:0]            seg,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame_start
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic              pending;
  logic [VW-1:0]     sh_val;
  logic [DIGITS-1:0] sh_dp;
  logic [VW-1:0]     dv;
  logic [DIGITS-1:0] ddp;

  logic              slot_end;
  logic              frame_end;
  logic              accept;
  logic [DIGITS-1:0] nz;
  logic [DIGITS-1:0] oh;
  logic [3:0]        nib;
  logic              dp_k;
  logic              blank_k;
  logic [6:0]        g7;
  logic [8:0]        seg_d;

  assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (idx == IW'(DIGITS - 1));
  assign in_ready  = !pending;
  assign accept    = in_valid && !pending;

  // nz[k]: some nibble from the MSB down to k is non-zero
  always_comb begin
    logic run;
    run = 1'b0;
    nz  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run   = run | (|dv[4*k +: 4]);
      nz[k] = run;
    end
  end

  always_comb begin
    nib     = '0;
    dp_k    = 1'b0;
    blank_k = 1'b0;
    oh      = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        nib     = dv[4*k +: 4];
        dp_k    = ddp[k];
        blank_k = lz_blank && (k != 0) && !nz[k];
        oh[k]   = 1'b1;
      end
    end
  end

  seg9_hex_lut u_lut (
    .nib   (nib),
    .blank (blank_k),
    .glyph (g7)
  );

  always_comb begin
    seg_d              = SEG_OFF;
    seg_d[SEG_A:SEG_G] = g7;
    seg_d[SEG_DP]      = dp_k;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      idx         <= '0;
      pending     <= 1'b0;
      sh_val      <= '0;
      sh_dp       <= '0;
      dv          <= '0;
      ddp         <= '0;
      seg         <= SEG_OFF;
      dig_sel     <= DIG_OFF;
      frame_start <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end)
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);

      // accept and frame load are exclusive: one needs pending low,
      // the other pending high
      if (accept) begin
        sh_val  <= in_value;
        sh_dp   <= in_dp;
        pending <= 1'b1;
      end else if (frame_end && pending) begin
        dv      <= sh_val;
        ddp     <= sh_dp;
        pending <= 1'b0;
      end

      frame_start <= (cnt == '0) && (idx == '0);
      if (cnt < CW'(BLANK_CYC)) begin
        seg     <= SEG_OFF;
        dig_sel <= DIG_OFF;
      end else begin
        seg     <= seg_d;
        dig_sel <= (DIG_ACTIVE_LOW != 0) ? ~oh : oh;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display: timed expectations
// are queued by the stimulus and consumed by a negedge monitor.
module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_value = '0;
  logic [3:0]  in_dp = '0;
  logic        in_valid = 1'b0;
  logic        lz_blank = 1'b0;
  logic        in_ready, in_ready_h;
  logic        frame_start, frame_start_h;
  logic [8:0]  seg, seg_h;
  logic [3:0]  dig_sel, dig_sel_h;

  always #5 clk = ~clk;

  seg_scan_display #(
    .DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .rst(rst), .in_value(in_value), .in_dp(in_dp),
    .in_valid(in_valid), .in_ready(in_ready), .lz_blank(lz_blank),
    .seg(seg), .dig_sel(dig_sel), .frame_start(frame_start)
  );

  seg_scan_display #(
    .DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .DIG_ACTIVE_LOW(0)
  ) dut_h (
    .clk(clk), .rst(rst), .in_value(in_value), .in_dp(in_dp),
    .in_valid(in_valid), .in_ready(in_ready_h), .lz_blank(lz_blank),
    .seg(seg_h), .dig_sel(dig_sel_h), .frame_start(frame_start_h)
  );

  localparam logic [8:0] G0  = 9'b111111000;
  localparam logic [8:0] G1  = 9'b011000000;
  localparam logic [8:0] G2  = 9'b110110100;
  localparam logic [8:0] G5  = 9'b101101100;
  localparam logic [8:0] GAD = 9'b111011110;
  localparam logic [8:0] GF  = 9'b100011100;
  localparam logic [8:0] BLK = 9'b000000000;
  localparam logic [8:0] BDP = 9'b000000010;

  typedef struct {
    int         p;
    bit         rdy;
    logic [8:0] v;
  } item_t;

  item_t q[$];
  int checks = 0;
  int errors = 0;
  int pcnt = -2;

  // output index since reset: -1 while reset is applied
  always @(posedge clk) begin
    if (rst) pcnt = -1;
    else if (pcnt >= -1) pcnt = pcnt + 1;
  end

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s p=%0d: got %0h expected %0h",
               nm, pcnt, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int c, d;
    logic [3:0] oh, ohn;
    if (pcnt == -1) begin
      chk("rst_seg", seg, 16'h0);
      chk("rst_dig", dig_sel, 16'hF);
      chk("rst_dig_h", dig_sel_h, 16'h0);
      chk("rst_fs", frame_start, 16'h0);
      chk("rst_rdy", in_ready, 16'h1);
    end else if (pcnt >= 0) begin
      c   = pcnt % 8;
      d   = (pcnt / 8) % 4;
      oh  = 4'b0001 << d;
      ohn = ~oh;
      chk("frame_start", frame_start, 16'(pcnt % 32 == 0));
      chk("frame_start_h", frame_start_h, 16'(pcnt % 32 == 0));
      if (c < 2) begin
        chk("gap_seg", seg, 16'h0);
        chk("gap_dig", dig_sel, 16'hF);
        chk("gap_dig_h", dig_sel_h, 16'h0);
      end else begin
        chk("lit_dig", dig_sel, ohn);
        chk("lit_dig_h", dig_sel_h, oh);
      end
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].p == pcnt) begin
          if (q[i].rdy) begin
            chk("in_ready", in_ready, q[i].v);
            chk("in_ready_h", in_ready_h, q[i].v);
          end else begin
            chk($sformatf("seg_d%0d", d), seg, q[i].v);
            chk($sformatf("seg_h_d%0d", d), seg_h, q[i].v);
          end
          q.delete(i);
        end else if (q[i].p < pcnt) begin
          checks++;
          errors++;
          $display("FAIL missed p=%0d: item at %0d", pcnt, q[i].p);
          q.delete(i);
        end
      end
    end
  end

  task automatic push_frame(int f, logic [8:0] s0, logic [8:0] s1,
                            logic [8:0] s2, logic [8:0] s3);
    logic [8:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++) begin
      q.push_back('{p: 32*f + 8*k + 2, rdy: 1'b0, v: s[k]});
      q.push_back('{p: 32*f + 8*k + 7, rdy: 1'b0, v: s[k]});
    end
  endtask

  task automatic push_rdy(int p, bit v);
    q.push_back('{p: p, rdy: 1'b1, v: {8'b0, v}});
  endtask

  task automatic wait_p(int x);
    int g = 0;
    while (pcnt != x && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (pcnt != x) begin
      checks++;
      errors++;
      $display("FAIL wait_p: got %0d expected %0d", pcnt, x);
    end
  endtask

  // input sampled by the edge that produces output index p
  task automatic offer(logic [15:0] v, logic [3:0] dp, int p);
    wait_p(p - 1);
    in_value = v;
    in_dp    = dp;
    in_valid = 1'b1;
    wait_p(p);
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    push_frame(0, G0, G0, G0, G0);
    push_frame(1, G0, G0, G0, G0);
    push_rdy(39, 1'b1);
    push_rdy(40, 1'b0);
    push_rdy(50, 1'b0);
    push_rdy(62, 1'b0);
    push_rdy(63, 1'b1);
    offer(16'h12AF, 4'b0010, 40);
    offer(16'h3333, 4'b1111, 45);
    push_frame(2, GF, GAD, G2, G1);

    push_frame(3, G0, G1, G2, G5);
    push_frame(4, G0, G1, G2, G5);
    push_rdy(93, 1'b1);
    push_rdy(94, 1'b0);
    push_rdy(95, 1'b1);
    push_rdy(126, 1'b1);
    push_rdy(127, 1'b0);
    push_rdy(158, 1'b0);
    push_rdy(159, 1'b1);
    offer(16'h5210, 4'b0000, 94);
    offer(16'h0050, 4'b0000, 127);

    push_frame(5, G0, G5, G0, G0);
    push_frame(6, G0, G5, BLK, BLK);
    wait_p(191);
    lz_blank = 1'b1;

    push_frame(7, G0, BLK, BDP, BLK);
    push_rdy(199, 1'b1);
    push_rdy(200, 1'b0);
    offer(16'h0000, 4'b0100, 200);

    push_rdy(259, 1'b1);
    push_rdy(260, 1'b0);
    offer(16'hFFFF, 4'b1111, 260);
    wait_p(267);
    rst = 1'b1;
    lz_blank = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    push_frame(0, G0, G0, G0, G0);
    push_frame(1, G0, G0, G0, G0);
    push_rdy(0, 1'b1);
    push_rdy(40, 1'b1);
    wait_p(70);
    chk("queue_drained", 16'(q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: timeout at pcnt=%0d", pcnt);
    $fatal(1);
  end

endmodule
